sobel_stream: RTL

//   Streaming, parametrised Sobel edge detector. Accepts raster-order pixels one per clock over a

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_line_buffer.sv | 24 ++
 rtl/sobel_stream.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - Sobel kernel constants, PIX_W-derived widths and magnitude saturation.
package sobel_pkg;

   localparam int GRAD_EXTRA = 3;
   localparam int MAG_EXTRA  = 4;

   // Kernel weights: outer taps and centre-row/column taps.
   localparam int K_EDGE = 1;
   localparam int K_MID  = 2;

   function automatic int grad_width(input int pix_w);
      return pix_w + GRAD_EXTRA;
   endfunction

   function automatic int mag_width(input int pix_w);
      return pix_w + MAG_EXTRA;
   endfunction

   function automatic int unsigned saturate(input int unsigned mag, input int unsigned pix_w);
      int unsigned max_val;
      max_val = (32'd1 << pix_w) - 32'd1;
      return (mag > max_val) ? max_val : mag;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - One-line delay: read-old-then-write at the same address when enabled.
module sobel_line_buffer #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 8,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             en_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   assign rd_data_o = mem_q[addr_i];

   always_ff @(posedge clk) begin
      if (en_i) begin
         mem_q[addr_i] <= wr_data_i;
      end
   end

endmodule

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - Streaming 3x3 Sobel magnitude over valid/ready; window -> gradients -> magnitude.
// SOBEL_THRESH_EN adds the thresh input and the registered out_edge output.
module sobel_stream
   import sobel_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int IMG_W = 512,
   parameter int IMG_H = 512
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pix,
`ifdef SOBEL_THRESH_EN
   input  logic [PIX_W-1:0] thresh,
   output logic             out_edge,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_mag,
   output logic             out_last
);

   localparam int GRAD_W = grad_width(PIX_W);
   localparam int MAG_W  = mag_width(PIX_W);
   localparam int COL_W  = $clog2(IMG_W);
   localparam int ROW_W  = $clog2(IMG_H);

   logic en;
   logic accept;

   logic [COL_W-1:0] col_q, col_d, eff_col;
   logic [ROW_W-1:0] row_q, row_d, eff_row;

   logic [PIX_W-1:0] lb0_rd, lb1_rd;

   logic [PIX_W-1:0] win_q [9];
   logic [PIX_W-1:0] win_d [9];
   logic             win_valid_q, win_valid_d;
   logic             win_last_q, win_last_d;

   logic [GRAD_W-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
   logic signed [GRAD_W-1:0] gx_q, gx_d, gy_q, gy_d;
   logic                     s1_valid_q, s1_last_q;

   logic [GRAD_W-1:0] gx_abs, gy_abs;
   logic [MAG_W-1:0]  mag;
   logic [PIX_W-1:0]  out_mag_q, out_mag_d;
   logic              out_valid_q, out_last_q;

   assign en        = !out_valid_q | out_ready;
   assign in_ready  = en & !rst;
   assign accept    = in_valid & in_ready;
   assign out_valid = out_valid_q;
   assign out_mag   = out_mag_q;
   assign out_last  = out_last_q;

   // in_sof forces the accepted pixel to (0,0) regardless of where the counters are.
   always_comb begin
      eff_col = in_sof ? '0 : col_q;
      eff_row = in_sof ? '0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      if (accept) begin
         if (eff_col == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (eff_row == ROW_W'(IMG_H - 1)) ? '0 : eff_row + ROW_W'(1);
         end else begin
            col_d = eff_col + COL_W'(1);
            row_d = eff_row;
         end
      end
   end

   sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
      .clk       (clk),
      .en_i      (accept),
      .addr_i    (eff_col),
      .wr_data_i (in_pix),
      .rd_data_o (lb0_rd)
   );

   sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
      .clk       (clk),
      .en_i      (accept),
      .addr_i    (eff_col),
      .wr_data_i (lb0_rd),
      .rd_data_o (lb1_rd)
   );

   always_comb begin
      win_d       = win_q;
      win_valid_d = accept && (eff_row >= ROW_W'(2)) && (eff_col >= COL_W'(2));
      win_last_d  = accept && (eff_row == ROW_W'(IMG_H - 1)) && (eff_col == COL_W'(IMG_W - 1));
      if (accept) begin
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = lb1_rd;
         win_d[3] = win_q[4];
         win_d[4] = win_q[5];
         win_d[5] = lb0_rd;
         win_d[6] = win_q[7];
         win_d[7] = win_q[8];
         win_d[8] = in_pix;
      end
   end

   always_comb begin
      gx_pos = GRAD_W'(K_EDGE) * GRAD_W'(win_q[2]) + GRAD_W'(K_MID) * GRAD_W'(win_q[5])
             + GRAD_W'(K_EDGE) * GRAD_W'(win_q[8]);
      gx_neg = GRAD_W'(K_EDGE) * GRAD_W'(win_q[0]) + GRAD_W'(K_MID) * GRAD_W'(win_q[3])
             + GRAD_W'(K_EDGE) * GRAD_W'(win_q[6]);
      gy_pos = GRAD_W'(K_EDGE) * GRAD_W'(win_q[6]) + GRAD_W'(K_MID) * GRAD_W'(win_q[7])
             + GRAD_W'(K_EDGE) * GRAD_W'(win_q[8]);
      gy_neg = GRAD_W'(K_EDGE) * GRAD_W'(win_q[0]) + GRAD_W'(K_MID) * GRAD_W'(win_q[1])
             + GRAD_W'(K_EDGE) * GRAD_W'(win_q[2]);
      gx_d   = gx_pos - gx_neg;
      gy_d   = gy_pos - gy_neg;
   end

   always_comb begin
      gx_abs    = gx_q[GRAD_W-1] ? GRAD_W'(-gx_q) : GRAD_W'(gx_q);
      gy_abs    = gy_q[GRAD_W-1] ? GRAD_W'(-gy_q) : GRAD_W'(gy_q);
      mag       = MAG_W'(gx_abs) + MAG_W'(gy_abs);
      out_mag_d = PIX_W'(saturate(32'(mag), PIX_W));
   end

`ifdef SOBEL_THRESH_EN
   logic out_edge_q;
   assign out_edge = out_edge_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         out_edge_q <= 1'b0;
      end else if (en) begin
         out_edge_q <= (out_mag_d >= thresh);
      end
   end
`endif

   // Every stage advances together on en, so a stalled output holds the whole pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= '0;
         end
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         gx_q        <= '0;
         gy_q        <= '0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         out_mag_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         win_q <= win_d;
         if (en) begin
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            s1_valid_q  <= win_valid_q;
            s1_last_q   <= win_last_q & win_valid_q;
            out_mag_q   <= out_mag_d;
            out_valid_q <= s1_valid_q;
            out_last_q  <= s1_last_q & s1_valid_q;
         end
      end
   end

endmodule
